cordic_sincos_frontend: RTL and testbench
=========================================

CORDIC_SINCOS_FRONTEND -- requirements
Module: cordic_sincos_frontend

Interface
REQ-001 SHALL have parameter DEPTH, default 32: maximum requests in flight plus buffered results; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: request valid.
REQ-005 SHALL have port in_ready, output, 1 bit: request accepted when high together with in_valid.
REQ-006 SHALL have port in_angle, input, 16 bits: signed angle in radians, Q3.13.
REQ-007 SHALL have port core_start, output, 1 bit: one-cycle issue pulse to the CORDIC core, which runs in rotation mode.
REQ-008 SHALL have port core_angle, output, 16 bits: signed folded angle, Q2.14.
REQ-009 SHALL have port core_result, input, 16 bits: signed sin from the core, Q2.14.
REQ-010 SHALL have port core_secondary, input, 16 bits: signed cos from the core, Q2.14.
REQ-011 SHALL have port core_valid, input, 1 bit: core result strobe; results return in issue order.
REQ-012 SHALL have port out_valid, output, 1 bit: result available.
REQ-013 SHALL have port out_ready, input, 1 bit: result consumed when high together with out_valid.
REQ-014 SHALL have port out_sin, output, 16 bits: signed sin, Q2.14.
REQ-015 SHALL have port out_cos, output, 16 bits: signed cos, Q2.14.
REQ-016 SHALL have port range_err, output, 1 bit: sticky flag, input angle was outside [-pi, pi].
REQ-017 SHALL have port proto_err, output, 1 bit: sticky flag, core_valid arrived with no request outstanding.
REQ-018 SHALL have port busy, output, 1 bit: credit count is nonzero.

Function
REQ-019 SHALL keep a credit counter (0..DEPTH) that increments on each input handshake, decrements on each output handshake, and does both in the same cycle without net change.
REQ-020 SHALL drive in_ready high exactly when the credit count is below DEPTH; in_ready is combinational from the counter only, never from in_valid.
REQ-021 SHALL clamp in_angle above PI_Q13 (0x6488) to PI_Q13 and below -PI_Q13 to -PI_Q13, and set range_err on that cycle.
REQ-022 SHALL fold angles: a > HALF_PI_Q13 (0x3244) becomes PI_Q13 - a; a < -HALF_PI_Q13 becomes -PI_Q13 - a; in both cases cos_neg=1, otherwise cos_neg=0.
REQ-023 SHALL form core_angle as the folded value shifted left by 1 (Q3.13 to Q2.14); the folded magnitude never exceeds 0x3244, so no overflow occurs.
REQ-024 SHALL register core_start and core_angle one cycle after the input handshake, and push cos_neg into the tag FIFO in that same cycle.
REQ-025 SHALL pop the tag FIFO on each core_valid, and register the corrected result into the result FIFO one cycle later: sin passes unchanged; cos is negated when the tag is 1, with -0x8000 saturating to 0x7FFF.
REQ-026 SHALL, when core_valid arrives with the tag FIFO empty, drop the result, set proto_err, and leave the credit count unchanged.
REQ-027 SHALL present the result FIFO first-word-fall-through: out_valid is high when the FIFO is non-empty and out_sin/out_cos show its head.
REQ-028 SHALL handle the FIFO full/empty limits and simultaneous events as follows: push and pop in the same cycle on a non-empty FIFO are both honoured; credit gating guarantees the result FIFO never overflows, so no full check is needed on core_valid.
REQ-029 SHALL accept one request per cycle and sustain throughput of 1 while out_ready stays high.
REQ-030 SHALL give the error flags the following behaviour: range_err and proto_err clear only on rst.

Reset
REQ-031 SHALL, on rst, clear these outputs: in_ready (rises the cycle after rst deasserts), core_start, core_angle, out_valid, out_sin, out_cos, range_err, proto_err, busy.
REQ-032 SHALL, on rst, clear the credit counter, both FIFO pointers, and the correction register.
REQ-033 SHALL, when rst asserts mid-operation, discard all in-flight requests; the integrator resets the core on the same rst, and core results arriving afterwards fall under REQ-026.

Structure
REQ-034 SHALL place PI_Q13, HALF_PI_Q13, the Q-format widths and the default DEPTH in a shared cordic package.
REQ-035 SHALL implement one sub-module, cordic_sync_fifo (parameterised width and depth, first-word-fall-through), instantiated twice: as the 1-bit tag FIFO and as the 32-bit result FIFO.
REQ-036 SHALL keep the CORDIC core outside this block, connected by the integrator.

Verification
REQ-037 SHALL cover: in_angle 0x0000 -> core_angle 0x0000, tag 0; out_sin 0x0000 ±8 LSB, out_cos 0x4000 ±8 LSB.
REQ-038 SHALL cover: in_angle 0x6488 (pi) -> core_angle 0x0000, tag 1; out_sin ≈0x0000, out_cos ≈0xC000.
REQ-039 SHALL cover: in_angle 0xB49A (-3pi/4) -> folded -pi/4 (0xE6DE Q3.13), core_angle 0xCDBC; out_sin ≈0xD2BF, out_cos ≈0xD2BF.
REQ-040 SHALL cover: in_angle 0x7000 -> clamped to pi, range_err=1; result as in REQ-038.
REQ-041 SHALL cover: 40 back-to-back requests with out_ready=0 -> exactly 32 accepted, then in_ready=0; out_ready=1 drains 32 results in order; no drops; proto_err stays 0.
REQ-042 SHALL cover: rst pulsed with 10 requests in flight -> next cycle out_valid=0 and busy=0; a stale core_valid then sets proto_err.

Source files
------------

// File: rtl/cordic_sincos_frontend_pkg.sv
// Shared constants, result payload and helpers for the CORDIC sin/cos front end.
package cordic_sincos_frontend_pkg;

   localparam int unsigned ANGLE_W       = 16;   // Q3.13 input angle
   localparam int unsigned DATA_W        = 16;   // Q2.14 core angle and results
   localparam int unsigned DEPTH_DEFAULT = 32;

   localparam logic signed [ANGLE_W-1:0] PI_Q13      = 16'sh6488;
   localparam logic signed [ANGLE_W-1:0] HALF_PI_Q13 = 16'sh3244;

   typedef struct packed {
      logic [DATA_W-1:0] sin_val;
      logic [DATA_W-1:0] cos_val;
   } sincos_t;

   // Two's-complement negate; the most negative code saturates to the most positive.
   function automatic logic [DATA_W-1:0] neg_sat(input logic [DATA_W-1:0] x);
      if (x == {1'b1, {(DATA_W-1){1'b0}}})
         return {1'b0, {(DATA_W-1){1'b1}}};
      return (~x) + DATA_W'(1);
   endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module cordic_sync_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cordic_sincos_frontend.sv
// Front end for an external rotation-mode CORDIC core: clamps and folds the
// angle into +-pi/2, tracks the cos sign through a tag FIFO, and buffers results.
module cordic_sincos_frontend
   import cordic_sincos_frontend_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_angle,
   output logic        core_start,
   output logic [15:0] core_angle,
   input  logic [15:0] core_result,
   input  logic [15:0] core_secondary,
   input  logic        core_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sin,
   output logic [15:0] out_cos,
   output logic        range_err,
   output logic        proto_err,
   output logic        busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]              credit;
   logic [CW-1:0]              credit_nxt;
   logic                       in_rst;
   logic                       in_fire;
   logic                       out_fire;
   logic signed [ANGLE_W-1:0]  angle;
   logic signed [ANGLE_W-1:0]  clamped;
   logic signed [ANGLE_W-1:0]  folded;
   logic                       out_of_range;
   logic                       cos_neg;
   logic                       tag_head;
   logic                       tag_empty;
   logic                       corr_valid;
   sincos_t                    corr;
   sincos_t                    res_head;
   logic                       res_empty;

   // in_rst holds in_ready low through reset and for the edge that releases it.
   assign in_ready  = ~in_rst & (credit < CW'(DEPTH));
   assign in_fire   = in_valid & in_ready;
   assign out_valid = ~res_empty;
   assign out_fire  = out_valid & out_ready;
   assign out_sin   = res_head.sin_val;
   assign out_cos   = res_head.cos_val;
   assign angle     = in_angle;

   always_comb begin
      clamped      = angle;
      out_of_range = 1'b0;
      folded       = 16'sh0000;
      cos_neg      = 1'b0;
      if (angle > PI_Q13) begin
         clamped      = PI_Q13;
         out_of_range = 1'b1;
      end else if (angle < -PI_Q13) begin
         clamped      = -PI_Q13;
         out_of_range = 1'b1;
      end
      // Reflect about +-pi/2: sin is preserved, cos changes sign.
      if (clamped > HALF_PI_Q13) begin
         folded  = PI_Q13 - clamped;
         cos_neg = 1'b1;
      end else if (clamped < -HALF_PI_Q13) begin
         folded  = -PI_Q13 - clamped;
         cos_neg = 1'b1;
      end else begin
         folded  = clamped;
      end
   end

   always_comb begin
      credit_nxt = credit;
      case ({in_fire, out_fire})
         2'b10:   credit_nxt = credit + CW'(1);
         2'b01:   credit_nxt = credit - CW'(1);
         default: credit_nxt = credit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_rst     <= 1'b1;
         credit     <= '0;
         busy       <= 1'b0;
         core_start <= 1'b0;
         core_angle <= '0;
         range_err  <= 1'b0;
         proto_err  <= 1'b0;
         corr_valid <= 1'b0;
         corr       <= '0;
      end else begin
         in_rst     <= 1'b0;
         credit     <= credit_nxt;
         busy       <= (credit_nxt != '0);
         core_start <= in_fire;
         if (in_fire) core_angle <= folded << 1;
         range_err  <= range_err | (in_fire & out_of_range);
         proto_err  <= proto_err | (core_valid & tag_empty);
         corr_valid <= core_valid & ~tag_empty;
         if (core_valid) begin
            corr.sin_val <= core_result;
            corr.cos_val <= tag_head ? neg_sat(core_secondary) : core_secondary;
         end
      end
   end

   cordic_sync_fifo #(
      .WIDTH (1),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_fire),
      .push_data (cos_neg),
      .pop       (core_valid),
      .head      (tag_head),
      .empty     (tag_empty)
   );

   cordic_sync_fifo #(
      .WIDTH ($bits(sincos_t)),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (corr_valid),
      .push_data (corr),
      .pop       (out_ready),
      .head      (res_head),
      .empty     (res_empty)
   );

endmodule

// File: tb/tb_cordic_sincos_frontend.sv
// Directed bench for cordic_sincos_frontend with a fixed-latency stand-in core.
module tb_cordic_sincos_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_angle;
   logic        core_start;
   logic [15:0] core_angle;
   logic [15:0] core_result;
   logic [15:0] core_secondary;
   logic        core_valid;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sin;
   logic [15:0] out_cos;
   logic        range_err;
   logic        proto_err;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic        inj_valid;
   logic [2:0]  pv;
   logic [15:0] pa [3];

   always #5 clk = ~clk;

   cordic_sincos_frontend #(.DEPTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_angle       (in_angle),
      .core_start     (core_start),
      .core_angle     (core_angle),
      .core_result    (core_result),
      .core_secondary (core_secondary),
      .core_valid     (core_valid),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sin        (out_sin),
      .out_cos        (out_cos),
      .range_err      (range_err),
      .proto_err      (proto_err),
      .busy           (busy)
   );

   // Stand-in core: hand-picked answers for the directed angles, otherwise (a, a+1).
   function automatic logic [15:0] model_sin(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h0000;
         16'hCDBC: return 16'hD2BF;
         16'h4910: return 16'h1111;
         default:  return a;
      endcase
   endfunction

   function automatic logic [15:0] model_cos(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h4000;
         16'hCDBC: return 16'h2D41;
         16'h4910: return 16'h8000;
         default:  return a + 16'd1;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pv <= 3'b000;
      end else begin
         pv    <= {pv[1:0], core_start};
         pa[0] <= core_angle;
         pa[1] <= pa[0];
         pa[2] <= pa[1];
      end
   end

   assign core_valid     = pv[2] | inj_valid;
   assign core_result    = inj_valid ? 16'h1234 : model_sin(pa[2]);
   assign core_secondary = inj_valid ? 16'h4321 : model_cos(pa[2]);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (!out_valid && n < 30) begin
         step();
         n++;
      end
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic single(input string tag, input logic [15:0] ang, input logic [15:0] exp_core,
                         input logic [15:0] exp_sin, input logic [15:0] exp_cos);
      in_valid = 1'b1;
      in_angle = ang;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check({tag, " core_start"}, 32'(core_start), 32'd1);
      check({tag, " core_angle"}, 32'(core_angle), 32'(exp_core));
      wait_out(tag);
      check({tag, " out_sin"}, 32'(out_sin), 32'(exp_sin));
      check({tag, " out_cos"}, 32'(out_cos), 32'(exp_cos));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " drained"}, 32'(out_valid), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      logic [15:0] exp_a;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_angle  = 16'h0000;
      out_ready = 1'b0;
      inj_valid = 1'b0;
      repeat (3) step();
      check("rst in_ready",   32'(in_ready),   32'd0);
      check("rst out_valid",  32'(out_valid),  32'd0);
      check("rst busy",       32'(busy),       32'd0);
      check("rst core_start", 32'(core_start), 32'd0);
      check("rst core_angle", 32'(core_angle), 32'd0);
      check("rst out_sin",    32'(out_sin),    32'd0);
      check("rst out_cos",    32'(out_cos),    32'd0);
      check("rst range_err",  32'(range_err),  32'd0);
      check("rst proto_err",  32'(proto_err),  32'd0);
      rst = 1'b0;
      step();
      check("post-rst in_ready", 32'(in_ready), 32'd1);

      single("zero",      16'h0000, 16'h0000, 16'h0000, 16'h4000);
      single("pi",        16'h6488, 16'h0000, 16'h0000, 16'hC000);
      single("m3pi4",     16'hB49A, 16'hCDBC, 16'hD2BF, 16'hD2BF);
      single("half_pi",   16'h3244, 16'h6488, 16'h6488, 16'h6489);
      single("m_half_pi", 16'hCDBC, 16'h9B78, 16'h9B78, 16'h9B79);
      single("cos_sat",   16'h4000, 16'h4910, 16'h1111, 16'h7FFF);
      check("range_err before clamp", 32'(range_err), 32'd0);
      single("clamp_pos", 16'h7000, 16'h0000, 16'h0000, 16'hC000);
      check("range_err after clamp", 32'(range_err), 32'd1);
      single("clamp_neg", 16'h8000, 16'h0000, 16'h0000, 16'hC000);

      // Back-to-back burst against a stalled consumer.
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_angle = 16'h0100 + 16'(acc * 16);
         if (in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      check("burst accepted", 32'(acc), 32'd32);
      check("burst in_ready", 32'(in_ready), 32'd0);
      check("burst busy", 32'(busy), 32'd1);
      repeat (10) step();
      out_ready = 1'b1;
      for (int j = 0; j < 32; j++) begin
         exp_a = (16'h0100 + 16'(j * 16)) << 1;
         check("burst out_valid", 32'(out_valid), 32'd1);
         check("burst out_sin", 32'(out_sin), 32'(exp_a));
         check("burst out_cos", 32'(out_cos), 32'(exp_a + 16'd1));
         step();
      end
      out_ready = 1'b0;
      check("burst empty", 32'(out_valid), 32'd0);
      check("burst idle", 32'(busy), 32'd0);
      check("burst proto_err", 32'(proto_err), 32'd0);
      check("burst in_ready back", 32'(in_ready), 32'd1);

      // Reset with requests in flight, then a stale core strobe.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_angle = 16'h0200;
         step();
      end
      in_valid = 1'b0;
      check("flight busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd0);
      check("midrst range_err", 32'(range_err), 32'd0);
      rst = 1'b0;
      step();
      check("midrst in_ready back", 32'(in_ready), 32'd1);
      check("stale proto_err before", 32'(proto_err), 32'd0);
      inj_valid = 1'b1;
      step();
      inj_valid = 1'b0;
      check("stale proto_err", 32'(proto_err), 32'd1);
      check("stale out_valid", 32'(out_valid), 32'd0);
      step();
      check("stale still empty", 32'(out_valid), 32'd0);
      check("stale busy", 32'(busy), 32'd0);
      check("proto_err sticky", 32'(proto_err), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
